// File: rtl/dose_alarm_scheduler_if.sv
// Bus between the dose alarm scheduler and its surroundings: time/ROM/button
// inputs in, BCD due time, alarm and statistics out.
interface dose_alarm_scheduler_if;
  logic        secondPulse;
  logic [23:0] timeBCD;
  logic [7:0]  doseInfo;
  logic        armPulse;
  logic        ackPulse;
  logic        cancelPulse;
  logic [23:0] nextDoseBCD;
  logic [3:0]  dueId;
  logic        alarm;
  logic        blink;
  logic [3:0]  takenCount;
  logic [3:0]  missedCount;
  logic [1:0]  state;

  modport master (
    output secondPulse, timeBCD, doseInfo, armPulse, ackPulse, cancelPulse,
    input  nextDoseBCD, dueId, alarm, blink, takenCount, missedCount, state
  );

  modport slave (
    input  secondPulse, timeBCD, doseInfo, armPulse, ackPulse, cancelPulse,
    output nextDoseBCD, dueId, alarm, blink, takenCount, missedCount, state
  );
endinterface

// File: rtl/dose_alarm_scheduler.sv
// Schedules the next medicine dose from the running BCD clock, raises a blinking
// alarm when it falls due and counts taken and missed doses.
//
// state | meaning
// IDLE  | no schedule, waiting for arm with a valid interval
// ARMED | waiting for the time of day to equal the due time
// ALARM | dose due, blinking until ack, timeout or cancel
module dose_alarm_scheduler #(
  parameter int ALARM_TIMEOUT = 60,
  parameter int COUNT_MAX     = 15
) (
  input logic                   clk,
  input logic                   rst,
  dose_alarm_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_ALARM = 2'b10
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(ALARM_TIMEOUT - 1);
  localparam logic [3:0] CNT_SAT  = 4'(COUNT_MAX);

  state_t      state_q;
  logic [23:0] next_q;
  logic [3:0]  id_q;
  logic [3:0]  interval_q;
  logic        blink_q;
  logic [3:0]  taken_q;
  logic [3:0]  missed_q;
  logic [7:0]  tmo_q;

  logic        interval_ok;
  logic [23:0] arm_next_d;
  logic [23:0] resched_d;
  logic [3:0]  taken_d;
  logic [3:0]  missed_d;

  // Advance the hour field by iv hours modulo 24; minutes and seconds pass through.
  function automatic logic [23:0] add_hours(input logic [23:0] t, input logic [3:0] iv);
    logic [6:0] h;
    logic [3:0] ht;
    logic [3:0] hu;
    h = {3'b000, t[23:20]} * 7'd10 + {3'b000, t[19:16]} + {3'b000, iv};
    h = h % 7'd24;
    if (h >= 7'd20) begin
      ht = 4'd2;
      hu = 4'(h - 7'd20);
    end else if (h >= 7'd10) begin
      ht = 4'd1;
      hu = 4'(h - 7'd10);
    end else begin
      ht = 4'd0;
      hu = 4'(h);
    end
    return {ht, hu, t[15:0]};
  endfunction

  always_comb begin
    interval_ok = (bus.doseInfo[3:0] != 4'd0) && (bus.doseInfo[3:0] <= 4'd12);
    arm_next_d  = add_hours(bus.timeBCD, bus.doseInfo[3:0]);
    resched_d   = add_hours(next_q, interval_q);
    taken_d     = (taken_q  < CNT_SAT) ? taken_q  + 4'd1 : taken_q;
    missed_d    = (missed_q < CNT_SAT) ? missed_q + 4'd1 : missed_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      next_q     <= 24'h0;
      id_q       <= 4'h0;
      interval_q <= 4'h0;
      blink_q    <= 1'b0;
      taken_q    <= 4'h0;
      missed_q   <= 4'h0;
      tmo_q      <= 8'h0;
    end else if (bus.cancelPulse) begin
      state_q <= S_IDLE;
      blink_q <= 1'b0;
      tmo_q   <= 8'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.armPulse && interval_ok) begin
            id_q       <= bus.doseInfo[7:4];
            interval_q <= bus.doseInfo[3:0];
            next_q     <= arm_next_d;
            state_q    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.timeBCD == next_q) begin
            state_q <= S_ALARM;
            tmo_q   <= 8'h0;
            blink_q <= 1'b0;
          end
        end
        S_ALARM: begin
          // Rescheduling is relative to the previous due time so the regimen never drifts.
          if (bus.ackPulse) begin
            taken_q <= taken_d;
            next_q  <= resched_d;
            state_q <= S_ARMED;
            blink_q <= 1'b0;
            tmo_q   <= 8'h0;
          end else if (bus.secondPulse) begin
            if (tmo_q == TMO_LAST) begin
              missed_q <= missed_d;
              next_q   <= resched_d;
              state_q  <= S_ARMED;
              blink_q  <= 1'b0;
              tmo_q    <= 8'h0;
            end else begin
              tmo_q   <= tmo_q + 8'd1;
              blink_q <= ~blink_q;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.nextDoseBCD = next_q;
  assign bus.dueId       = id_q;
  assign bus.alarm       = blink_q;
  assign bus.blink       = blink_q;
  assign bus.takenCount  = taken_q;
  assign bus.missedCount = missed_q;
  assign bus.state       = state_q;

endmodule

// File: doc/dose_alarm_scheduler.md
Name: dose_alarm_scheduler

Overview:
- Sits directly downstream of the time-of-day counter and the prescription ROM.
- Consumes the running BCD time (HH:MM:SS) and the ROM's medicine-ID/interval byte, and schedules the next dose time.
- Raises a blinking alarm when the next dose falls due, and tracks acknowledged and missed doses.
- Its BCD outputs feed the seven-segment decoders; its alarm bit drives an LED.

Parameters:
- ALARM_TIMEOUT, 60, seconds the alarm stays active without acknowledge before the dose is declared missed (1..255).
- COUNT_MAX, 15, saturation value of taken/missed counters (fits 4 bits).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- secondPulse  input  1  one-clk-wide pulse once per second, aligned with time updates.
- timeBCD  input  24  current time: [23:20] H tens, [19:16] H units, [15:12] M tens, [11:8] M units, [7:4] S tens, [3:0] S units.
- doseInfo  input  8  ROM content: [7:4] medicine ID, [3:0] interval in hours (binary, 1..12; 0 or >12 = invalid).
- armPulse  input  1  one-clk pulse (shaped start button): begin schedule.
- ackPulse  input  1  one-clk pulse (shaped button): dose taken.
- cancelPulse  input  1  one-clk pulse: abandon schedule, return to IDLE.
- nextDoseBCD  output  24  scheduled due time, same packing as timeBCD.
- dueId  output  4  medicine ID latched at arm.
- alarm  output  1  high in ALARM state and blinking.
- blink  output  1  toggles on each secondPulse while in ALARM; 0 otherwise.
- takenCount  output  4  acknowledged doses, saturating.
- missedCount  output  4  timed-out doses, saturating.
- state  output  2  00 IDLE, 01 ARMED, 10 ALARM.

Behaviour:
- Reset (rst=0, async): state IDLE; nextDoseBCD=0; dueId=0; alarm=0; blink=0; takenCount=0; missedCount=0; timeout counter=0.
- IDLE:
  - armPulse with a valid interval latches dueId=doseInfo[7:4] and the interval.
  - nextDoseBCD = timeBCD with hours advanced by the interval; -> ARMED next cycle.
  - armPulse with an invalid interval is ignored; the block stays IDLE.
- Hour advance, BCD:
  - h = 10*Ht + Hu; h' = (h + interval) mod 24; re-encode to BCD.
  - Minutes and seconds are copied unchanged from the base time.
  - All stored/output digits are valid BCD.
- ARMED:
  - When timeBCD == nextDoseBCD (full 24-bit compare): -> ALARM, timeout counter cleared, blink=0.
  - Equality only. A time set that jumps over the due time does not fire until the time next equals it.
- ALARM:
  - alarm = blink; blink toggles on each secondPulse; timeout counter increments on secondPulse.
  - ackPulse: takenCount+1 (saturating), nextDoseBCD advanced by the interval from the previous due time (not ack time) -> ARMED.
  - Timeout counter reaching ALARM_TIMEOUT: missedCount+1 (saturating), same reschedule -> ARMED.
- Simultaneous events:
  - ackPulse and timeout in the same cycle: ack wins (taken, not missed).
  - cancelPulse has priority over everything in any state: -> IDLE; alarm/blink=0; counters and nextDoseBCD retained.
  - armPulse in ARMED/ALARM is ignored.
  - ackPulse outside ALARM is ignored.
- Latency:
  - State and outputs update on the clk edge after the triggering input.
  - alarm goes high at the first secondPulse after the ALARM entry (blink starts at 0 and toggles to 1).
- Counters saturate at COUNT_MAX; they are never cleared except by rst.
- Reset asserted mid-ALARM clears everything immediately, without waiting for clk.

Test Plan:
- Reset -> all outputs 0, state=00. Arm at 08:15:30 with doseInfo=8'h36 -> dueId=3, nextDoseBCD=14:15:30, state=01.
- Arm at 22:00:00 with interval 4 -> nextDoseBCD=02:00:00 (midnight wrap). Arm with interval 0 or 13 -> stays IDLE.
- Drive time to 14:15:30 -> state=10 next cycle. Over 3 secondPulses blink goes 1,0,1. ackPulse -> takenCount=1, nextDoseBCD=20:15:30, state=01, alarm=0.
- ALARM_TIMEOUT=5, no ack -> after the 5th secondPulse missedCount=1 and the dose is rescheduled. Ack on the same cycle as the 5th pulse -> takenCount increments, missedCount does not.
- cancelPulse during ALARM -> IDLE, alarm=0, counts kept. rst low mid-ALARM -> outputs 0 asynchronously.
- 16 acks -> takenCount holds at 15.
